atomic_unit: RTL and testbench

RV32A execution unit in the MEM stage. It performs LR.W, SC.W and all AMO*.W operations as multi-cycle read-modify-write sequences on a dedicated data-memory request port, and owns the LR/SC reservation. While a sequence is in flight it drives `atomic_unit_stall` into the pipeline control path, and it returns the rd value once the sequence completes.

---
 rtl/atomic_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_atomic_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomic_unit.sv
// atomic_unit
// RV32A execution unit sitting in the MEM stage. Runs LR.W, SC.W and the
// AMO*.W family as multi-cycle read-modify-write sequences on a private
// data-memory port and owns the single LR/SC reservation.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               valid, unflushed atomic instruction in MEM
//   funct5              instr[31:27], selects the atomic operation
//   addr                rs1 value (effective address)
//   rs2_data            forwarded rs2 operand
//   advance             MEM/WB register enabled this cycle
//   clear_reservation   trap / interrupt / mret taken
//   atomic_unit_stall   freezes the pipeline while a sequence is in flight
//   result              rd write-back value
//   result_valid        result is valid (DONE state)
//   misaligned_exc      addr[1:0] != 0 (DONE state)
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_ack/mem_rdata   memory completion and read data
module atomic_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [4:0]      funct5,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            advance,
    input  logic            clear_reservation,
    output logic            atomic_unit_stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            misaligned_exc,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MODIFY,
        WRITE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [4:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] amo_new;
    logic            mis_q;
    logic            res_valid;
    logic [XLEN-1:0] res_addr;

    logic is_lr_q;
    logic is_sc_q;
    logic is_sc_in;
    logic misaligned_in;
    logic sc_ok;

    assign is_lr_q       = (op_q == F_LR);
    assign is_sc_q       = (op_q == F_SC);
    assign is_sc_in      = (funct5 == F_SC);
    assign misaligned_in = (addr[1:0] != 2'b00);
    assign sc_ok         = res_valid && (res_addr == addr);

    // Stall is gated by reset_n so every output is 0 while reset is held,
    // even if start is still asserted by the pipeline.
    assign atomic_unit_stall = reset_n &&
                               (((state == IDLE) && start) ||
                                (state == READ) || (state == MODIFY) ||
                                (state == WRITE));
    assign result_valid      = (state == DONE);
    assign misaligned_exc    = (state == DONE) && mis_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned_in) begin
                        state_next = DONE;
                    end else if (is_sc_in) begin
                        state_next = sc_ok ? WRITE : DONE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_next = is_lr_q ? DONE : MODIFY;
                end
            end
            MODIFY: state_next = WRITE;
            WRITE: begin
                if (mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (advance) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Unknown funct5 codes fall through to the default arm and act as SWAP.
    always_comb begin
        amo_new = rs2_q;
        case (op_q)
            F_ADD:  amo_new = old_q + rs2_q;
            F_XOR:  amo_new = old_q ^ rs2_q;
            F_AND:  amo_new = old_q & rs2_q;
            F_OR:   amo_new = old_q | rs2_q;
            F_MIN:  amo_new = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
            F_MAX:  amo_new = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
            F_MINU: amo_new = (old_q < rs2_q) ? old_q : rs2_q;
            F_MAXU: amo_new = (old_q > rs2_q) ? old_q : rs2_q;
            default: amo_new = rs2_q;
        endcase
    end

    // Datapath and registered memory port. Request fields are only loaded on
    // entry to READ/WRITE, so they stay stable while waiting for mem_ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            rs2_q     <= '0;
            old_q     <= '0;
            mis_q     <= 1'b0;
            result    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= funct5;
                        addr_q <= addr;
                        rs2_q  <= rs2_data;
                        mis_q  <= misaligned_in;
                        result <= '0;
                        if (!misaligned_in) begin
                            if (is_sc_in) begin
                                if (sc_ok) begin
                                    mem_req   <= 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= addr;
                                    mem_wdata <= rs2_data;
                                end else begin
                                    result <= {{(XLEN-1){1'b0}}, 1'b1};
                                end
                            end else begin
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= addr;
                            end
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        old_q   <= mem_rdata;
                        result  <= mem_rdata;
                        mem_req <= 1'b0;
                    end
                end
                MODIFY: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= amo_new;
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_sc_q) begin
                            result <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reservation: every aligned SC drops it, LR sets it on read completion,
    // and clear_reservation overrides both because it is applied last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_addr  <= '0;
        end else begin
            if ((state == IDLE) && start && !misaligned_in && is_sc_in) begin
                res_valid <= 1'b0;
            end
            if ((state == WRITE) && mem_ack && is_sc_q) begin
                res_valid <= 1'b0;
            end
            if ((state == READ) && mem_ack && is_lr_q) begin
                res_valid <= 1'b1;
                res_addr  <= addr_q;
            end
            if (clear_reservation) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_atomic_unit.sv
// tb_atomic_unit
// Directed bench for atomic_unit. A small word memory model answers the
// DUT's request port with a programmable ack delay, counts transactions and
// flags any change of a pending request before it is acknowledged.
module tb_atomic_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [4:0]  funct5;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        advance;
    logic        clear_reservation;
    logic        atomic_unit_stall;
    logic [31:0] result;
    logic        result_valid;
    logic        misaligned_exc;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int compared = 0;
    int failed   = 0;

    atomic_unit #(.XLEN(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .funct5            (funct5),
        .addr              (addr),
        .rs2_data          (rs2_data),
        .advance           (advance),
        .clear_reservation (clear_reservation),
        .atomic_unit_stall (atomic_unit_stall),
        .result            (result),
        .result_valid      (result_valid),
        .misaligned_exc    (misaligned_exc),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model state
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          rd_delay = 0;
    int          wr_delay = 0;
    int          delay_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          req_cycles = 0;
    int          unstable = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_wdata = '0;
    logic        pend_we = 1'b0;

    assign mem_ack   = mem_req && (delay_cnt >= (mem_we ? wr_delay : rd_delay));
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr[9:2]] <= pre_data;
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && mem_ack) begin
            delay_cnt <= 0;
            if (mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end else if (mem_req) begin
            delay_cnt <= delay_cnt + 1;
        end else begin
            delay_cnt <= 0;
        end
        if (pend && mem_req &&
            ((mem_addr != pend_addr) || (mem_we != pend_we) || (mem_wdata != pend_wdata)))
            unstable <= unstable + 1;
        pend       <= mem_req && !mem_ack;
        pend_addr  <= mem_addr;
        pend_we    <= mem_we;
        pend_wdata <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Presents one atomic instruction and runs until DONE (or timeout).
    // Returns at negedge+1 of the first DONE cycle with start still high.
    task automatic applyStimulus(input logic [4:0] f5, input logic [31:0] a,
                                 input logic [31:0] r2, output int stalls,
                                 output logic got_done);
        @(negedge clk);
        start    = 1'b1;
        funct5   = f5;
        addr     = a;
        rs2_data = r2;
        advance  = 1'b0;
        stalls   = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (result_valid) begin
                got_done = 1'b1;
                break;
            end
            if (atomic_unit_stall) stalls++;
            @(negedge clk);
        end
    endtask

    task automatic retireOp;
        advance = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        advance = 1'b0;
    endtask

    int   st;
    logic dn;
    int   rd0, wr0, rq0;
    logic found;

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        funct5 = '0;
        addr = '0;
        rs2_data = '0;
        advance = 1'b0;
        clear_reservation = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_stall", {31'd0, atomic_unit_stall}, 32'd0);
        checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_misal", {31'd0, misaligned_exc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // AMOADD: 5 + 7
        preload(32'h100, 32'd5);
        rd0 = rd_cnt; wr0 = wr_cnt;
        applyStimulus(5'b00000, 32'h100, 32'd7, st, dn);
        checkOutput("add_done", {31'd0, dn}, 32'd1);
        checkOutput("add_result", result, 32'd5);
        checkOutput("add_stall", 32'(st), 32'd4);
        checkOutput("add_reads", 32'(rd_cnt - rd0), 32'd1);
        checkOutput("add_writes", 32'(wr_cnt - wr0), 32'd1);
        checkOutput("add_waddr", last_waddr, 32'h100);
        checkOutput("add_wdata", last_wdata, 32'd12);
        retireOp();
        #1;
        checkOutput("add_idle_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("add_result_held", result, 32'd5);

        // LR then SC to the same address
        preload(32'h200, 32'hA);
        applyStimulus(5'b00010, 32'h200, 32'd0, st, dn);
        checkOutput("lr_result", result, 32'hA);
        checkOutput("lr_stall", 32'(st), 32'd2);
        retireOp();
        wr0 = wr_cnt;
        applyStimulus(5'b00011, 32'h200, 32'h55, st, dn);
        checkOutput("sc_result", result, 32'd0);
        checkOutput("sc_stall", 32'(st), 32'd2);
        checkOutput("sc_writes", 32'(wr_cnt - wr0), 32'd1);
        checkOutput("sc_wdata", last_wdata, 32'h55);
        checkOutput("sc_waddr", last_waddr, 32'h200);
        retireOp();
        rq0 = req_cycles;
        applyStimulus(5'b00011, 32'h200, 32'h66, st, dn);
        checkOutput("sc_again_result", result, 32'd1);
        checkOutput("sc_again_noreq", 32'(req_cycles - rq0), 32'd0);
        retireOp();

        // SC to a different address fails and drops the reservation
        applyStimulus(5'b00010, 32'h200, 32'd0, st, dn);
        checkOutput("lr2_result", result, 32'h55);
        retireOp();
        rq0 = req_cycles;
        applyStimulus(5'b00011, 32'h204, 32'd9, st, dn);
        checkOutput("scx_result", result, 32'd1);
        checkOutput("scx_stall", 32'(st), 32'd1);
        checkOutput("scx_noreq", 32'(req_cycles - rq0), 32'd0);
        retireOp();
        applyStimulus(5'b00011, 32'h200, 32'd9, st, dn);
        checkOutput("scx_second", result, 32'd1);
        retireOp();

        // Signed vs unsigned compare with 0xFFFFFFFF and 1
        preload(32'h140, 32'hFFFF_FFFF);
        applyStimulus(5'b10000, 32'h140, 32'd1, st, dn);
        checkOutput("min_result", result, 32'hFFFF_FFFF);
        checkOutput("min_wdata", last_wdata, 32'hFFFF_FFFF);
        retireOp();
        applyStimulus(5'b11000, 32'h140, 32'd1, st, dn);
        checkOutput("minu_wdata", last_wdata, 32'd1);
        retireOp();
        preload(32'h140, 32'hFFFF_FFFF);
        applyStimulus(5'b10100, 32'h140, 32'd1, st, dn);
        checkOutput("max_wdata", last_wdata, 32'd1);
        retireOp();
        preload(32'h140, 32'hFFFF_FFFF);
        applyStimulus(5'b11100, 32'h140, 32'd1, st, dn);
        checkOutput("maxu_wdata", last_wdata, 32'hFFFF_FFFF);
        retireOp();

        // Logic ops, wrapping add, swap and an undefined code acting as swap
        preload(32'h180, 32'hF0F0_1234);
        applyStimulus(5'b00100, 32'h180, 32'hFF00_FF00, st, dn);
        checkOutput("xor_wdata", last_wdata, 32'h0FF0_ED34);
        retireOp();
        preload(32'h180, 32'hF0F0_1234);
        applyStimulus(5'b01100, 32'h180, 32'hFF00_FF00, st, dn);
        checkOutput("and_wdata", last_wdata, 32'hF000_1200);
        retireOp();
        preload(32'h180, 32'hF0F0_1234);
        applyStimulus(5'b01000, 32'h180, 32'hFF00_FF00, st, dn);
        checkOutput("or_wdata", last_wdata, 32'hFFF0_FF34);
        retireOp();
        preload(32'h180, 32'hFFFF_FFFF);
        applyStimulus(5'b00000, 32'h180, 32'd2, st, dn);
        checkOutput("addwrap_wdata", last_wdata, 32'd1);
        retireOp();
        applyStimulus(5'b00001, 32'h180, 32'hCAFE_0001, st, dn);
        checkOutput("swap_result", result, 32'd1);
        checkOutput("swap_wdata", last_wdata, 32'hCAFE_0001);
        retireOp();
        applyStimulus(5'b00111, 32'h180, 32'h1357_9BDF, st, dn);
        checkOutput("undef_result", result, 32'hCAFE_0001);
        checkOutput("undef_wdata", last_wdata, 32'h1357_9BDF);
        retireOp();

        // Read ack delayed by 3 cycles (mem[0x100] holds 12)
        rd_delay = 3;
        applyStimulus(5'b00000, 32'h100, 32'd1, st, dn);
        checkOutput("bp_done", {31'd0, dn}, 32'd1);
        checkOutput("bp_stall", 32'(st), 32'd7);
        checkOutput("bp_result", result, 32'd12);
        checkOutput("bp_wdata", last_wdata, 32'd13);
        checkOutput("bp_stable", 32'(unstable), 32'd0);
        retireOp();
        rd_delay = 0;

        // DONE held with advance low; then clear_reservation between LR and SC
        preload(32'h1C0, 32'h77);
        rd0 = rd_cnt;
        applyStimulus(5'b00010, 32'h1C0, 32'd0, st, dn);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("hold_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("hold_stall", {31'd0, atomic_unit_stall}, 32'd0);
        checkOutput("hold_reads", 32'(rd_cnt - rd0), 32'd1);
        checkOutput("hold_result", result, 32'h77);
        retireOp();
        clear_reservation = 1'b1;
        @(negedge clk);
        clear_reservation = 1'b0;
        rq0 = req_cycles;
        applyStimulus(5'b00011, 32'h1C0, 32'h88, st, dn);
        checkOutput("clr_sc_result", result, 32'd1);
        checkOutput("clr_sc_noreq", 32'(req_cycles - rq0), 32'd0);
        retireOp();

        // Misaligned accesses; reservation survives a misaligned SC
        rq0 = req_cycles;
        applyStimulus(5'b00000, 32'h102, 32'd1, st, dn);
        checkOutput("mis_exc", {31'd0, misaligned_exc}, 32'd1);
        checkOutput("mis_stall", 32'(st), 32'd1);
        checkOutput("mis_noreq", 32'(req_cycles - rq0), 32'd0);
        retireOp();
        #1;
        checkOutput("mis_exc_clear", {31'd0, misaligned_exc}, 32'd0);
        preload(32'h240, 32'h33);
        applyStimulus(5'b00010, 32'h240, 32'd0, st, dn);
        checkOutput("mis_lr_exc", {31'd0, misaligned_exc}, 32'd0);
        retireOp();
        applyStimulus(5'b00011, 32'h242, 32'h44, st, dn);
        checkOutput("mis_sc_exc", {31'd0, misaligned_exc}, 32'd1);
        retireOp();
        applyStimulus(5'b00011, 32'h240, 32'h44, st, dn);
        checkOutput("mis_then_sc", result, 32'd0);
        checkOutput("mis_then_sc_wd", last_wdata, 32'h44);
        retireOp();

        // Reset asserted while an AMO sits in WRITE
        preload(32'h300, 32'h10);
        applyStimulus(5'b00010, 32'h300, 32'd0, st, dn);
        retireOp();
        wr_delay = 5;
        found = 1'b0;
        @(negedge clk);
        start = 1'b1; funct5 = 5'b00000; addr = 32'h300; rs2_data = 32'd5;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_req && mem_we) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rstw_in_write", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        checkOutput("rstw_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rstw_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rstw_addr", mem_addr, 32'd0);
        checkOutput("rstw_wdata", mem_wdata, 32'd0);
        checkOutput("rstw_result", result, 32'd0);
        checkOutput("rstw_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rstw_misal", {31'd0, misaligned_exc}, 32'd0);
        checkOutput("rstw_stall", {31'd0, atomic_unit_stall}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        wr_delay = 0;
        checkOutput("rstw_mem", mem[8'hC0], 32'h10);
        rq0 = req_cycles;
        applyStimulus(5'b00011, 32'h300, 32'h99, st, dn);
        checkOutput("rstw_sc_result", result, 32'd1);
        checkOutput("rstw_sc_noreq", 32'(req_cycles - rq0), 32'd0);
        retireOp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
